// File: rtl/pic_intensity_accumulator.sv
// Accumulates one picture (2^CNT_W pixel intensities) into a sum and hands it downstream
// with a wrapping picture index over a valid/ready handshake.
module pic_intensity_accumulator #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned CNT_W = 14,
    parameter int unsigned SUM_W = 22,
    parameter int unsigned IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pic_restart,
    input  logic             pix_valid,
    output logic             pix_ready,
    input  logic [PIX_W-1:0] pix_data,
    output logic             sum_valid,
    input  logic             sum_ready,
    output logic [SUM_W-1:0] sum_data,
    output logic [IDX_W-1:0] sum_idx,
    output logic [CNT_W-1:0] pix_count,
    output logic             busy
);

    logic [SUM_W-1:0] acc_q, acc_d;
    logic [SUM_W-1:0] sum_data_q, sum_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] sum_idx_q, sum_idx_d;
    logic [IDX_W-1:0] next_idx_q, next_idx_d;
    logic             sum_valid_q, sum_valid_d;

    logic [SUM_W-1:0] acc_sum;
    logic [CNT_W-1:0] cnt_inc;
    logic             one_picture;
    logic             accept;

    assign acc_sum = acc_q + SUM_W'(pix_data);
    // Carry-out of the count incrementer marks the last pixel of a picture.
    assign {one_picture, cnt_inc} = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    // Registered-state only: no path from sum_ready, so a same-cycle drain does not
    // admit the stalled last pixel until the following cycle.
    assign pix_ready = ~(one_picture & sum_valid_q);
    assign accept    = pix_valid & pix_ready & ~pic_restart;

    always_comb begin
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sum_data_d  = sum_data_q;
        sum_idx_d   = sum_idx_q;
        next_idx_d  = next_idx_q;
        sum_valid_d = sum_valid_q;

        if (sum_valid_q && sum_ready) begin
            sum_valid_d = 1'b0;
        end

        if (pic_restart) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            if (one_picture) begin
                sum_data_d  = acc_sum;
                sum_idx_d   = next_idx_q;
                next_idx_d  = next_idx_q + IDX_W'(1);
                sum_valid_d = 1'b1;
                acc_d       = '0;
                cnt_d       = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            sum_data_q  <= '0;
            sum_idx_q   <= '0;
            next_idx_q  <= '0;
            sum_valid_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            sum_data_q  <= sum_data_d;
            sum_idx_q   <= sum_idx_d;
            next_idx_q  <= next_idx_d;
            sum_valid_q <= sum_valid_d;
        end
    end

    assign sum_valid = sum_valid_q;
    assign sum_data  = sum_data_q;
    assign sum_idx   = sum_idx_q;
    assign pix_count = cnt_q;
    assign busy      = (cnt_q != '0);

endmodule

// File: tb/tb_pic_intensity_accumulator.sv
// Bench for pic_intensity_accumulator, run with a 256-pixel picture to keep simulation short;
// a picture-level model predicts every output each cycle.
module tb_pic_intensity_accumulator;

    localparam int unsigned PIX_W = 8;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned SUM_W = 16;
    localparam int unsigned IDX_W = 5;
    localparam int unsigned P     = 1 << CNT_W;
    localparam int unsigned IW    = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pic_restart = 1'b0;
    logic             pix_valid = 1'b0;
    logic             pix_ready;
    logic [PIX_W-1:0] pix_data = '0;
    logic             sum_valid;
    logic             sum_ready = 1'b0;
    logic [SUM_W-1:0] sum_data;
    logic [IDX_W-1:0] sum_idx;
    logic [CNT_W-1:0] pix_count;
    logic             busy;

    pic_intensity_accumulator #(
        .PIX_W(PIX_W),
        .CNT_W(CNT_W),
        .SUM_W(SUM_W),
        .IDX_W(IDX_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pic_restart(pic_restart),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .pix_data   (pix_data),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready),
        .sum_data   (sum_data),
        .sum_idx    (sum_idx),
        .pix_count  (pix_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int rdy_low = 0;
    int unsigned m_acc, m_cnt, m_next, m_sd, m_si;
    bit m_sv;
    int unsigned obs_sum[$];
    int unsigned obs_idx[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit m_rdy();
        return !(m_cnt == P - 1 && m_sv);
    endfunction

    task automatic model_edge();
        bit rdy;
        rdy = m_rdy();
        if (m_sv && sum_ready) m_sv = 1'b0;
        if (pic_restart) begin
            m_acc = 0;
            m_cnt = 0;
        end else if (pix_valid && rdy) begin
            m_acc += pix_data;
            m_cnt++;
            if (m_cnt == P) begin
                m_sd   = m_acc;
                m_si   = m_next;
                m_next = (m_next + 1) % IW;
                m_sv   = 1'b1;
                m_acc  = 0;
                m_cnt  = 0;
            end
        end
    endtask

    task automatic check_outputs();
        chk("sum_valid", 32'(sum_valid), 32'(m_sv));
        chk("sum_data", 32'(sum_data), m_sd);
        chk("sum_idx", 32'(sum_idx), m_si);
        chk("pix_count", 32'(pix_count), m_cnt);
        chk("busy", 32'(busy), 32'(m_cnt != 0));
        chk("pix_ready", 32'(pix_ready), 32'(m_rdy()));
    endtask

    task automatic cycle();
        if (pix_ready === 1'b0) rdy_low++;
        if (sum_valid === 1'b1 && sum_ready) begin
            obs_sum.push_back(32'(sum_data));
            obs_idx.push_back(32'(sum_idx));
        end
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    // Asserted mid-cycle: outputs are checked before any clock edge arrives.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        m_acc = 0; m_cnt = 0; m_next = 0; m_sd = 0; m_si = 0; m_sv = 1'b0;
        check_outputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // kind 0: constant val, 1: ramp, 2: random valid/data. rmode 0: ready=1, 1: random, 2: hold.
    task automatic stream(input int n, input int kind, input int val, input int rmode);
        int done = 0;
        int guard = 0;
        while (done < n && guard < 8 * n + 100) begin
            pix_valid = (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            pix_data  = (kind == 0) ? PIX_W'(val) :
                        (kind == 1) ? PIX_W'(done % 256) : PIX_W'($urandom_range(0, 255));
            if (rmode == 0) sum_ready = 1'b1;
            else if (rmode == 1) sum_ready = 1'($urandom_range(0, 1));
            if (pix_valid && m_rdy()) done++;
            cycle();
            guard++;
        end
        pix_valid = 1'b0;
        chk("stream_done", 32'(done), 32'(n));
    endtask

    task automatic idle(input int n);
        pix_valid = 1'b0;
        sum_ready = 1'b1;
        repeat (n) cycle();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned e;
        do_reset();

        // Full-scale picture, no stalls expected.
        obs_sum.delete(); obs_idx.delete(); rdy_low = 0;
        stream(P, 0, 255, 0);
        idle(2);
        chk("t1_no_stall", 32'(rdy_low), 0);
        chk("t1_count", 32'(obs_sum.size()), 1);
        if (obs_sum.size() == 1) begin
            chk("t1_sum", obs_sum[0], P * 255);
            chk("t1_idx", obs_idx[0], 0);
        end

        // Ramp then all ones.
        do_reset();
        obs_sum.delete(); obs_idx.delete();
        stream(P, 1, 0, 0);
        stream(P, 0, 1, 0);
        idle(2);
        e = 0;
        for (int i = 0; i < int'(P); i++) e += i % 256;
        chk("t2_count", 32'(obs_sum.size()), 2);
        if (obs_sum.size() == 2) begin
            chk("t2_ramp_sum", obs_sum[0], e);
            chk("t2_ramp_idx", obs_idx[0], 0);
            chk("t2_ones_sum", obs_sum[1], P);
            chk("t2_ones_idx", obs_idx[1], 1);
        end

        // Backpressure on the last pixel while the previous sum waits.
        do_reset();
        obs_sum.delete(); obs_idx.delete();
        sum_ready = 1'b0;
        stream(P, 0, 255, 2);
        stream(P - 1, 0, 2, 2);
        chk("t3_cnt", 32'(pix_count), P - 1);
        chk("t3_ready_low", 32'(pix_ready), 0);
        chk("t3_hold", 32'(sum_data), P * 255);
        pix_valid = 1'b1; pix_data = 8'd2; sum_ready = 1'b0;
        cycle();
        chk("t3_still_low", 32'(pix_ready), 0);
        chk("t3_cnt_held", 32'(pix_count), P - 1);
        sum_ready = 1'b1;
        cycle();
        chk("t3_drained", 32'(sum_valid), 0);
        chk("t3_ready_back", 32'(pix_ready), 1);
        chk("t3_cnt_after_drain", 32'(pix_count), P - 1);
        sum_ready = 1'b0;
        cycle();
        pix_valid = 1'b0;
        chk("t3_valid", 32'(sum_valid), 1);
        chk("t3_sum", 32'(sum_data), P * 2);
        chk("t3_idx", 32'(sum_idx), 1);
        chk("t3_cnt_zero", 32'(pix_count), 0);
        idle(2);
        chk("t3_count", 32'(obs_sum.size()), 2);
        if (obs_sum.size() == 2) begin
            chk("t3_sum0", obs_sum[0], P * 255);
            chk("t3_sum1", obs_sum[1], P * 2);
        end

        // Index wrap over 33 zero pictures with random output backpressure.
        do_reset();
        obs_sum.delete(); obs_idx.delete();
        for (int p = 0; p < 33; p++) stream(P, 0, 0, 1);
        idle(3);
        chk("t4_count", 32'(obs_idx.size()), 33);
        for (int i = 0; i < obs_idx.size(); i++) begin
            chk("t4_idx", obs_idx[i], i % IW);
            chk("t4_sum", obs_sum[i], 0);
        end

        // Soft restart drops the in-progress picture and the pixel offered with it.
        stream(100, 0, 10, 0);
        pic_restart = 1'b1; pix_valid = 1'b1; pix_data = 8'd99; sum_ready = 1'b1;
        cycle();
        pic_restart = 1'b0; pix_valid = 1'b0;
        chk("t5_cnt", 32'(pix_count), 0);
        chk("t5_busy", 32'(busy), 0);
        obs_sum.delete(); obs_idx.delete();
        stream(P, 0, 1, 0);
        idle(3);
        chk("t5_count", 32'(obs_sum.size()), 1);
        if (obs_sum.size() == 1) begin
            chk("t5_sum", obs_sum[0], P);
            chk("t5_idx", obs_idx[0], 33 % IW);
        end

        // Random valid/data/ready soak against the model.
        stream(3 * P, 2, 0, 1);
        idle(3);

        // Asynchronous reset mid-picture with a pending sum.
        sum_ready = 1'b0;
        stream(P, 0, 5, 2);
        stream(50, 0, 7, 2);
        chk("t6_pending", 32'(sum_valid), 1);
        chk("t6_busy", 32'(busy), 1);
        do_reset();
        obs_sum.delete(); obs_idx.delete();
        stream(P, 0, 255, 0);
        idle(3);
        chk("t6_count", 32'(obs_sum.size()), 1);
        if (obs_sum.size() == 1) begin
            chk("t6_sum", obs_sum[0], P * 255);
            chk("t6_idx", obs_idx[0], 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
